// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared definitions for the M-stage data-memory responder.
//   - dm_state_t : FSM state encodings (S_IDLE, S_WAIT, S_RESP)
//   - BE_*       : byte-enable masks a store may legally use
//   - be_is_legal: flags whether a byte-enable mask is one of the legal masks
package dm_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dm_state_t;

  // Legal store shapes: single bytes, aligned halfwords, full word.
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_is_legal(input logic [3:0] be);
    logic ok;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_responder_be_merge.sv
// dm_be_merge: combinational byte-lane merge for stores.
// Ports:
//   old_word    in  32  current contents of the addressed word
//   wdata       in  32  lane-aligned store data
//   be          in  4   byte-lane enables
//   merged_word out 32  old_word with enabled lanes replaced by wdata
//   be_legal    out 1   be is one of the legal store masks
module dm_be_merge
  import dm_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] merged_word,
  output logic        be_legal
);

  // Per-lane select between stored byte and incoming byte.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged_word[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged_word[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    be_legal = be_is_legal(be);
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle memory-side responder for the M-stage data port.
// Accepts one load/store at a time (req_valid/req_ready), waits WAIT_CYCLES
// cycles, then presents the result on rsp_valid/rsp_ready.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words stored
//   WAIT_CYCLES  wait states between accept and response (0..15)
//   BASE_ADDR    byte address of word 0
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous reset, active-low
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept (high only in IDLE)
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address, [1:0] ignored for word select
//   req_be     in   4   byte-lane enables for stores
//   req_wdata  in   32  lane-aligned store data
//   req_pc     in   32  PC of issuing instruction (store logging only)
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   initiator takes response
//   rsp_rdata  out  32  word read for loads; 0 for stores and errors
//   rsp_err    out  1   address out of range or illegal store be
// Build option:
//   DM_DISPLAY_EN  when defined, every committed error-free store prints
//                  one line; otherwise req_pc has no effect.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Range limits are held in 33 bits so BASE_ADDR + span cannot wrap.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [32:0] LIMIT_ADDR = {1'b0, BASE_ADDR} + SPAN_BYTES;
  localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT  = (WAIT_CYCLES == 0);

  dm_state_t   state_r;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic             acc_we_s;
  logic [31:0]      acc_addr_s;
  logic [3:0]       acc_be_s;
  logic [31:0]      acc_wdata_s;
  logic [31:0]      offset_s;
  logic [IDX_W-1:0] idx_s;
  logic             in_range_s;
  logic [31:0]      mem_rd_s;
  logic [31:0]      merged_s;
  logic             be_legal_s;
  logic             accept_s;
  logic             commit_s;
  logic             acc_err_s;
  logic             wr_en_s;
  logic [31:0]      rd_data_s;

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // Access source: live request when committing straight from IDLE (zero wait), latched copy otherwise.
  always_comb begin
    if (state_r == S_IDLE) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_be_s    = req_be;
      acc_wdata_s = req_wdata;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_be_s    = be_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Address decode; range test is done on 33-bit values to forbid wrap.
  always_comb begin
    offset_s   = acc_addr_s - BASE_ADDR;
    idx_s      = offset_s[IDX_W+1:2];
    in_range_s = ({1'b0, acc_addr_s} >= {1'b0, BASE_ADDR}) &&
                 ({1'b0, acc_addr_s} <  LIMIT_ADDR);
    if (in_range_s) begin
      mem_rd_s = mem_r[idx_s];
    end else begin
      mem_rd_s = 32'h0000_0000;
    end
  end

  dm_be_merge u_merge (
    .old_word    (mem_rd_s),
    .wdata       (acc_wdata_s),
    .be          (acc_be_s),
    .merged_word (merged_s),
    .be_legal    (be_legal_s)
  );

  // Commit point: the edge that moves the FSM into RESP.
  always_comb begin
    accept_s = req_valid && req_ready_r;
    if (state_r == S_IDLE) begin
      commit_s = accept_s && ZERO_WAIT;
    end else if (state_r == S_WAIT) begin
      commit_s = (cnt_r == WAIT_LAST);
    end else begin
      commit_s = 1'b0;
    end
    acc_err_s = !in_range_s || (acc_we_s && !be_legal_s);
    wr_en_s   = commit_s && acc_we_s && !acc_err_s;
    if (acc_err_s || acc_we_s) begin
      rd_data_s = 32'h0000_0000;
    end else begin
      rd_data_s = mem_rd_s;
    end
  end

  // Request/response FSM with wait counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      be_r        <= 4'b0000;
      wdata_r     <= 32'h0000_0000;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            be_r        <= req_be;
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            if (ZERO_WAIT) begin
              state_r     <= S_RESP;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= rd_data_s;
              rsp_err_r   <= acc_err_s;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (commit_s) begin
            state_r     <= S_RESP;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rd_data_s;
            rsp_err_r   <= acc_err_s;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_r     <= S_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= 4'd0;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: cleared on reset, written only by an error-free committed store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

`ifdef DM_DISPLAY_EN
  logic [31:0] pc_r;
  logic [31:0] acc_pc_s;
  logic [31:0] word_addr_s;
  logic        unused_s;

  // Keep the issuing PC alongside the latched request for the store log.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= 32'h0000_0000;
    end else if (accept_s) begin
      pc_r <= req_pc;
    end
  end

  // Log PC and word address: live request on a zero-wait commit, latched otherwise.
  always_comb begin
    if (state_r == S_IDLE) begin
      acc_pc_s = req_pc;
    end else begin
      acc_pc_s = pc_r;
    end
    word_addr_s = BASE_ADDR + {offset_s[31:2], 2'b00};
  end

  assign unused_s = ^offset_s[1:0];

  // One log line per committed store, printed at the commit edge.
  always_ff @(posedge clk) begin
    if (reset && wr_en_s) begin
      $display("%d@%h: *%h <= %h", $time, acc_pc_s, word_addr_s, merged_s);
    end
  end
`else
  logic unused_s;
  // req_pc only feeds the store log, which is compiled out here.
  assign unused_s = ^{req_pc, offset_s[1:0], offset_s[31:IDX_W+2]};
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  // DUT with WAIT_CYCLES=1, BASE_ADDR=0, DEPTH_WORDS=1024
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, req_pc, rsp_rdata;
  logic [3:0]  req_be;
  // DUT with WAIT_CYCLES=0, BASE_ADDR=0x100, DEPTH_WORDS=16
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_req_pc, b_rsp_rdata;
  logic [3:0]  b_req_be;

  exp_t sb_q[$];
  int   total    = 0;
  int   pass_cnt = 0;

  dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dm_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0100)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_be(b_req_be), .req_wdata(b_req_wdata), .req_pc(b_req_pc),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on dut; returns the response seen and the clock count
  // from the accept edge (inclusive) to the first edge with rsp_valid high.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input bit ack,
                       output logic [31:0] rdata, output logic err, output int lat, output bit tmo);
    int g;
    tmo = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
    req_pc = $urandom;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    if (!req_ready) tmo = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) tmo = 1'b1;
    rdata = rsp_rdata;
    err   = rsp_err;
    if (ack) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL reset_hold: got rdy=%b vld=%b rd=%h err=%b expected 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset_release: got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  // Run a list of accesses on dut, checking each response and its latency.
  task automatic run_ops(input string name, input logic we [], input logic [31:0] addr [],
                         input logic [3:0] be [], input logic [31:0] wd [],
                         input logic [31:0] xr [], input logic xe []);
    logic [31:0] rd; logic er; int lat; bit tmo; exp_t e;
    for (int i = 0; i < we.size(); i++) begin
      sb_q.push_back('{rdata: xr[i], err: xe[i]});
      issue(we[i], addr[i], be[i], wd[i], 1'b1, rd, er, lat, tmo);
      e = sb_q.pop_front();
      total++;
      if (tmo) $display("FAIL %s_timeout[%0d]: got no response expected response", name, i);
      else pass_cnt++;
      total++;
      if (rd !== e.rdata || er !== e.err)
        $display("FAIL %s_rsp[%0d]: got rdata=%h err=%b expected rdata=%h err=%b",
                 name, i, rd, er, e.rdata, e.err);
      else pass_cnt++;
      total++;
      if (lat !== 2) $display("FAIL %s_latency[%0d]: got %0d expected 2", name, i, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_store_load();
    run_ops("store_load", '{1'b1, 1'b0}, '{32'h10, 32'h10}, '{4'hF, 4'hF},
            '{32'h1234_5678, 32'h0}, '{32'h0, 32'h1234_5678}, '{1'b0, 1'b0});
  endtask

  task automatic test_byte_lane();
    run_ops("byte_lane", '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
            '{32'h20, 32'h20, 32'h22, 32'h24, 32'h24},
            '{4'hF, 4'h4, 4'h0, 4'h3, 4'h0},
            '{32'hAABB_CCDD, 32'h00EE_0000, 32'h0, 32'h0000_9876, 32'h0},
            '{32'h0, 32'h0, 32'hAAEE_CCDD, 32'h0, 32'h0000_9876},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_errors();
    run_ops("errors", '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            '{32'h1000, 32'h20, 32'h20, 32'hFFC, 32'hFFC, 32'hFFFF_FFFC},
            '{4'hF, 4'h5, 4'hF, 4'hF, 4'hF, 4'hF},
            '{32'h0, 32'h1111_1111, 32'h0, 32'h7777_0001, 32'h0, 32'h0},
            '{32'h0, 32'h0, 32'hAAEE_CCDD, 32'h0, 32'h7777_0001, 32'h0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int lat; bit tmo;
    sb_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    issue(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, er, lat, tmo);
    total++;
    if (tmo) $display("FAIL hold_timeout: got no response expected response");
    else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== sb_q[0].rdata || req_ready !== 1'b0)
        $display("FAIL hold_stable[%0d]: got vld=%b rd=%h rdy=%b expected 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, sb_q[0].rdata);
      else pass_cnt++;
    end
    void'(sb_q.pop_front());
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL hold_release: got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_be = 4'hF; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) reset = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL abort_norsp[%0d]: got vld=%b rdy=%b expected 0 1", c, rsp_valid, req_ready);
      else pass_cnt++;
    end
    run_ops("abort_load", '{1'b0, 1'b0}, '{32'h40, 32'h10}, '{4'hF, 4'hF},
            '{32'h0, 32'h0}, '{32'h0, 32'h0}, '{1'b0, 1'b0});
  endtask

  // Zero-wait instance: requests offered every cycle, rsp_ready tied high.
  task automatic test_back_to_back();
    localparam int NOPS = 11;
    logic        op_we [NOPS] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] op_ad [NOPS] = '{32'h100, 32'h104, 32'h100, 32'h104, 32'hFC, 32'h140,
                                  32'h13C, 32'h108, 32'h108, 32'h13E, 32'h13C};
    logic [3:0]  op_be [NOPS] = '{4'hF, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h6, 4'hF, 4'hC, 4'hF};
    logic [31:0] op_wd [NOPS] = '{32'hCAFE_F00D, 32'h0000_BEEF, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h1234_5678, 32'h0, 32'h5566_0000, 32'h0};
    logic [31:0] model [16];
    int k = 0; int n_rsp = 0; int last_cyc = 0;
    exp_t e; logic ok; int idx;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    b_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && n_rsp < NOPS; cyc++) begin
      @(negedge clk);
      if (b_rsp_valid) begin
        total++;
        if (sb_q.size() == 0) begin
          $display("FAIL b2b_extra: got unexpected response expected none");
        end else begin
          e = sb_q.pop_front();
          if (b_rsp_rdata !== e.rdata || b_rsp_err !== e.err)
            $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b expected rdata=%h err=%b",
                     n_rsp, b_rsp_rdata, b_rsp_err, e.rdata, e.err);
          else pass_cnt++;
        end
        if (n_rsp > 0) begin
          total++;
          if (cyc - last_cyc !== 2)
            $display("FAIL b2b_spacing[%0d]: got %0d expected 2", n_rsp, cyc - last_cyc);
          else pass_cnt++;
        end
        last_cyc = cyc;
        n_rsp++;
      end
      if (b_req_ready && k < NOPS) begin
        b_req_valid = 1'b1; b_req_we = op_we[k]; b_req_addr = op_ad[k];
        b_req_be = op_be[k]; b_req_wdata = op_wd[k]; b_req_pc = 32'h0000_4000 + 32'(k * 4);
        ok  = (op_ad[k] >= 32'h100) && (op_ad[k] < 32'h140);
        idx = ok ? int'((op_ad[k] - 32'h100) >> 2) : 0;
        if (op_we[k]) begin
          ok = ok && (op_be[k] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
          if (ok)
            for (int l = 0; l < 4; l++)
              if (op_be[k][l]) model[idx][8*l +: 8] = op_wd[k][8*l +: 8];
          sb_q.push_back('{rdata: 32'h0, err: !ok});
        end else begin
          sb_q.push_back('{rdata: ok ? model[idx] : 32'h0, err: !ok});
        end
        k++;
      end else if (b_req_ready) begin
        b_req_valid = 1'b0;
      end
    end
    b_req_valid = 1'b0;
    total++;
    if (n_rsp !== NOPS) $display("FAIL b2b_count: got %0d expected %0d", n_rsp, NOPS);
    else pass_cnt++;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0; req_wdata = 32'h0;
    req_pc = 32'h0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_be = 4'h0;
    b_req_wdata = 32'h0; b_req_pc = 32'h0; b_rsp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_byte_lane();
    test_errors();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
